// File: rtl/nvdla_cmac_wt_seq.sv
// ---------------------------------------------------------------------------
// nvdla_cmac_wt_seq
//
// Sequencer for the CMAC two-bank (ping-pong) weight shadow storage.
// Weight atoms from CSC fill one bank (the fill bank) while the MAC cells
// compute out of the other.
//
// At every data stripe start the compute bank swaps to the next full bank.
// At that point the previously active bank is released for refilling.
//
// After the layer-end atom the block waits out the MAC pipeline latency.
// It then pulses done back to the CMAC register file.
//
// Optional build macro:
//   NVDLA_CMAC_SEQ_PERF_EN - adds seq2reg_stall_cnt. This is a saturating
//                            count of RUN cycles with an active bank but no
//                            data atom offered.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   reg2seq_op_en, reg2seq_stripe_num: layer start pulse, stripes-1
//   sc2mac_wt_pvld / sc2mac_wt_sel   : weight atom valid, per-cell select
//   sc2mac_dat_pvld / sc2mac_dat_pd  : data atom valid, payload
//                                      [6]=stripe_st [7]=stripe_end
//                                      [8]=layer_end
//   wt_wr_bank, wt_wr_en             : fill bank pointer, per-cell write enable
//   mac_rd_bank                      : bank the MAC cells compute from
//   dat_go, dat_go_pd                : registered accepted data atom
//   seq2reg_busy/done/err            : status to the register file
//   stripe_cnt                       : stripes started in current layer
// ---------------------------------------------------------------------------
module nvdla_cmac_wt_seq #(
    parameter int CMAC_ATOMK_HALF = 8,
    parameter int MAC_LAT         = 7,
    parameter int STRIPE_W        = 14
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic                       reg2seq_op_en,
    input  logic [STRIPE_W-1:0]        reg2seq_stripe_num,
    input  logic                       sc2mac_wt_pvld,
    input  logic [CMAC_ATOMK_HALF-1:0] sc2mac_wt_sel,
    input  logic                       sc2mac_dat_pvld,
    input  logic [8:0]                 sc2mac_dat_pd,
    output logic                       wt_wr_bank,
    output logic [CMAC_ATOMK_HALF-1:0] wt_wr_en,
    output logic                       mac_rd_bank,
    output logic                       dat_go,
    output logic [8:0]                 dat_go_pd,
    output logic                       seq2reg_busy,
    output logic                       seq2reg_done,
    output logic [3:0]                 seq2reg_err,
    output logic [STRIPE_W-1:0]        stripe_cnt
`ifdef NVDLA_CMAC_SEQ_PERF_EN
    ,
    output logic [31:0]                seq2reg_stall_cnt
`endif
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                     state_reg;
    logic [1:0]                 bank_full_reg;
    logic [1:0]                 bank_full_next;
    logic [CMAC_ATOMK_HALF-1:0] wt_acc_reg  [2];
    logic [CMAC_ATOMK_HALF-1:0] wt_acc_next [2];
    logic                       fill_ptr_reg;
    logic                       cons_ptr_reg;
    logic                       act_vld_reg;
    logic [DW-1:0]              drain_cnt_reg;

    logic                       active;
    logic                       wt_fire;
    logic                       wt_ovf;
    logic [CMAC_ATOMK_HALF-1:0] acc_new;
    logic                       fill_done;
    logic                       is_run;
    logic                       dat_ok;
    logic                       dat_acc;
    logic                       dat_unf;
    logic                       stripe_inc;
    logic                       layer_end;
    logic [STRIPE_W-1:0]        cnt_post;
    logic [STRIPE_W-1:0]        stripe_exp;
    logic                       drain_end;
    logic                       bank_clr;

    // Weight writes are judged on the registered bank_full.
    // As a result, a write that lands in a bank-release cycle still sees
    // the pre-release state.
    assign active    = (state_reg != ST_IDLE);
    assign wt_fire   = active && sc2mac_wt_pvld && !bank_full_reg[fill_ptr_reg];
    assign wt_ovf    = active && sc2mac_wt_pvld &&  bank_full_reg[fill_ptr_reg];
    assign acc_new   = wt_acc_reg[fill_ptr_reg] | sc2mac_wt_sel;
    assign fill_done = wt_fire && (&acc_new);

    // A stripe start needs the next bank to be full.
    // Any other atom needs a bank already active.
    assign is_run     = (state_reg == ST_RUN);
    assign dat_ok     = sc2mac_dat_pd[6] ? bank_full_reg[cons_ptr_reg] : act_vld_reg;
    assign dat_acc    = is_run && sc2mac_dat_pvld &&  dat_ok;
    assign dat_unf    = is_run && sc2mac_dat_pvld && !dat_ok;
    assign stripe_inc = dat_acc && sc2mac_dat_pd[6];
    assign layer_end  = sc2mac_dat_pd[8];
    assign cnt_post   = stripe_cnt + {{(STRIPE_W-1){1'b0}}, stripe_inc};
    assign stripe_exp = reg2seq_stripe_num + 1'b1;

    // The compute bank is released either by the next stripe start
    // or by the end of the drain.
    assign drain_end = (state_reg == ST_DRAIN) && (drain_cnt_reg == '0);
    assign bank_clr  = (stripe_inc && act_vld_reg) || drain_end;

    // Release and fill-complete always target different banks.
    // The released bank is full, and a fill only happens into an empty bank.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_full_next[gi] =
                (fill_done && (fill_ptr_reg == 1'(gi))) ? 1'b1 :
                (bank_clr  && (mac_rd_bank  == 1'(gi))) ? 1'b0 :
                bank_full_reg[gi];
            assign wt_acc_next[gi] =
                (wt_fire && (fill_ptr_reg == 1'(gi))) ?
                    (fill_done ? '0 : acc_new) : wt_acc_reg[gi];
        end
        for (gi = 0; gi < CMAC_ATOMK_HALF; gi++) begin : g_wen
            assign wt_wr_en[gi] = wt_fire & sc2mac_wt_sel[gi];
        end
    endgenerate

    assign wt_wr_bank   = fill_ptr_reg;
    assign seq2reg_busy = active;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_reg     <= ST_IDLE;
            bank_full_reg <= 2'b00;
            wt_acc_reg[0] <= '0;
            wt_acc_reg[1] <= '0;
            fill_ptr_reg  <= 1'b0;
            cons_ptr_reg  <= 1'b0;
            act_vld_reg   <= 1'b0;
            drain_cnt_reg <= '0;
            mac_rd_bank   <= 1'b0;
            dat_go        <= 1'b0;
            dat_go_pd     <= '0;
            seq2reg_done  <= 1'b0;
            seq2reg_err   <= '0;
            stripe_cnt    <= '0;
        end else begin
            dat_go       <= 1'b0;
            seq2reg_done <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (reg2seq_op_en) begin
                    state_reg     <= ST_RUN;
                    stripe_cnt    <= '0;
                    seq2reg_err   <= '0;
                    bank_full_reg <= 2'b00;
                    wt_acc_reg[0] <= '0;
                    wt_acc_reg[1] <= '0;
                    fill_ptr_reg  <= 1'b0;
                    cons_ptr_reg  <= 1'b0;
                    act_vld_reg   <= 1'b0;
                end
            end else begin
                bank_full_reg <= bank_full_next;
                wt_acc_reg    <= wt_acc_next;
                if (fill_done) begin
                    fill_ptr_reg <= ~fill_ptr_reg;
                end
                if (wt_ovf) begin
                    seq2reg_err[0] <= 1'b1;
                end
                if (reg2seq_op_en) begin
                    seq2reg_err[3] <= 1'b1;
                end
                if (state_reg == ST_RUN) begin
                    if (dat_unf) begin
                        seq2reg_err[1] <= 1'b1;
                    end
                    if (dat_acc) begin
                        dat_go    <= 1'b1;
                        dat_go_pd <= sc2mac_dat_pd;
                        if (stripe_inc) begin
                            mac_rd_bank  <= cons_ptr_reg;
                            cons_ptr_reg <= ~cons_ptr_reg;
                            act_vld_reg  <= 1'b1;
                            stripe_cnt   <= cnt_post;
                        end
                        if (layer_end) begin
                            if (cnt_post != stripe_exp) begin
                                seq2reg_err[2] <= 1'b1;
                            end
                            state_reg     <= ST_DRAIN;
                            drain_cnt_reg <= DW'(MAC_LAT - 1);
                        end
                    end
                end else begin
                    // DRAIN: let the last atom's result leave the array.
                    if (drain_end) begin
                        seq2reg_done <= 1'b1;
                        act_vld_reg  <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 1'b1;
                    end
                end
            end
        end
    end

`ifdef NVDLA_CMAC_SEQ_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_IDLE) && reg2seq_op_en) begin
            stall_cnt_reg <= '0;
        end else if (is_run && !sc2mac_dat_pvld && act_vld_reg &&
                     (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign seq2reg_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_nvdla_cmac_wt_seq.sv
// ---------------------------------------------------------------------------
// Testbench for nvdla_cmac_wt_seq.
//
// The bench runs directed scenarios followed by randomized layers.
// Each cycle's outputs are compared against a behavioural model of the
// bank/stripe rules. The model keeps the banks as "cells loaded" masks and
// counts the drain down in cycles remaining.
// ---------------------------------------------------------------------------
module tb_nvdla_cmac_wt_seq;
    localparam int K   = 8;
    localparam int LAT = 7;
    localparam int SW  = 14;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          op_en = 1'b0;
    logic [SW-1:0] stripe_num = '0;
    logic          wt_pvld = 1'b0;
    logic [K-1:0]  wt_sel = '0;
    logic          dat_pvld = 1'b0;
    logic [8:0]    dat_pd = '0;

    logic          wt_wr_bank;
    logic [K-1:0]  wt_wr_en;
    logic          mac_rd_bank;
    logic          dat_go;
    logic [8:0]    dat_go_pd;
    logic          seq2reg_busy;
    logic          seq2reg_done;
    logic [3:0]    seq2reg_err;
    logic [SW-1:0] stripe_cnt;
`ifdef NVDLA_CMAC_SEQ_PERF_EN
    logic [31:0]   seq2reg_stall_cnt;
`endif

    nvdla_cmac_wt_seq #(
        .CMAC_ATOMK_HALF(K),
        .MAC_LAT(LAT),
        .STRIPE_W(SW)
    ) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rstn    (rstn),
        .reg2seq_op_en      (op_en),
        .reg2seq_stripe_num (stripe_num),
        .sc2mac_wt_pvld     (wt_pvld),
        .sc2mac_wt_sel      (wt_sel),
        .sc2mac_dat_pvld    (dat_pvld),
        .sc2mac_dat_pd      (dat_pd),
        .wt_wr_bank         (wt_wr_bank),
        .wt_wr_en           (wt_wr_en),
        .mac_rd_bank        (mac_rd_bank),
        .dat_go             (dat_go),
        .dat_go_pd          (dat_go_pd),
        .seq2reg_busy       (seq2reg_busy),
        .seq2reg_done       (seq2reg_done),
        .seq2reg_err        (seq2reg_err),
`ifdef NVDLA_CMAC_SEQ_PERF_EN
        .seq2reg_stall_cnt  (seq2reg_stall_cnt),
`endif
        .stripe_cnt         (stripe_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int           m_phase;          // 0 idle, 1 computing, 2 draining
    bit           m_full [2];
    bit [K-1:0]   m_loaded [2];
    int           m_fill, m_cons, m_rd, m_stripes, m_drain_left;
    bit           m_act, m_go, m_done;
    bit [8:0]     m_gopd;
    bit [3:0]     m_err;
    bit [31:0]    m_stall;

    int           cycle = 0;
    int           go_cnt = 0;
    int           last_go = 0;
    int           done_cyc = 0;
    logic [K-1:0] last_wen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_full[0] = 0; m_full[1] = 0;
        m_loaded[0] = '0; m_loaded[1] = '0;
        m_fill = 0; m_cons = 0; m_rd = 0; m_stripes = 0; m_drain_left = 0;
        m_act = 0; m_go = 0; m_done = 0; m_gopd = '0; m_err = '0; m_stall = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_edge();
        bit pfull [2];
        bit pact;
        bit ok;
        int prd;
        pfull = m_full; pact = m_act; prd = m_rd; ok = 0;
        m_go = 0; m_done = 0;
        if (m_phase == 0) begin
            if (op_en) begin
                m_phase = 1; m_stripes = 0; m_err = '0;
                m_full[0] = 0; m_full[1] = 0; m_loaded[0] = '0; m_loaded[1] = '0;
                m_fill = 0; m_cons = 0; m_act = 0; m_stall = '0;
            end
            return;
        end
        if (op_en) m_err[3] = 1;
        if (m_phase == 1 && !dat_pvld && pact && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (wt_pvld) begin
            if (pfull[m_fill]) m_err[0] = 1;
            else begin
                m_loaded[m_fill] |= wt_sel;
                if (&m_loaded[m_fill]) begin
                    m_loaded[m_fill] = '0;
                    m_full[m_fill] = 1;
                    m_fill ^= 1;
                end
            end
        end
        if (m_phase == 1) begin
            if (dat_pvld) begin
                if (dat_pd[6]) begin
                    if (pfull[m_cons]) begin
                        if (pact) m_full[prd] = 0;
                        m_rd = m_cons; m_cons ^= 1; m_act = 1; m_stripes++; ok = 1;
                    end else m_err[1] = 1;
                end else if (pact) ok = 1;
                else m_err[1] = 1;
                if (ok) begin
                    m_go = 1; m_gopd = dat_pd;
                    if (dat_pd[8]) begin
                        if ((m_stripes % 16384) != ((int'(stripe_num) + 1) % 16384)) m_err[2] = 1;
                        m_phase = 2; m_drain_left = LAT;
                    end
                end
            end
        end else begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_done = 1; m_full[m_rd] = 0; m_act = 0; m_phase = 0;
            end
        end
    endtask

    // One clock cycle: check write enables mid-cycle, advance, check registered outputs.
    task automatic step();
        logic [K-1:0] ew;
        ew = (m_phase != 0 && wt_pvld && !m_full[m_fill]) ? wt_sel : '0;
        #1;
        last_wen = wt_wr_en;
        chk("wt_wr_en", 32'(wt_wr_en), 32'(ew));
        chk("wt_wr_bank", 32'(wt_wr_bank), 32'(m_fill));
        @(posedge clk);
        model_edge();
        cycle++;
        #1;
        chk("busy", 32'(seq2reg_busy), 32'(m_phase != 0));
        chk("done", 32'(seq2reg_done), 32'(m_done));
        chk("dat_go", 32'(dat_go), 32'(m_go));
        if (m_go) chk("dat_go_pd", 32'(dat_go_pd), 32'(m_gopd));
        chk("err", 32'(seq2reg_err), 32'(m_err));
        chk("stripe_cnt", 32'(stripe_cnt), 32'(m_stripes % 16384));
        chk("mac_rd_bank", 32'(mac_rd_bank), 32'(m_rd));
`ifdef NVDLA_CMAC_SEQ_PERF_EN
        chk("stall_cnt", seq2reg_stall_cnt, m_stall);
`endif
        if (dat_go === 1'b1) begin go_cnt++; last_go = cycle; end
        if (seq2reg_done === 1'b1) done_cyc = cycle;
        $display("cyc %0d op=%0b wv=%0b sel=%02h dv=%0b pd=%03h | wen=%02h go=%0b rd=%0b sc=%0d err=%04b done=%0b",
                 cycle, op_en, wt_pvld, wt_sel, dat_pvld, dat_pd, last_wen, dat_go,
                 mac_rd_bank, stripe_cnt, seq2reg_err, seq2reg_done);
    endtask

    task automatic clear_inputs();
        op_en = 0; wt_pvld = 0; wt_sel = '0; dat_pvld = 0; dat_pd = '0;
    endtask

    task automatic op_start(input int num);
        stripe_num = SW'(num); op_en = 1; step(); op_en = 0;
    endtask

    task automatic wt(input logic [K-1:0] sel);
        wt_pvld = 1; wt_sel = sel; step(); wt_pvld = 0; wt_sel = '0;
    endtask

    task automatic fill8();
        for (int i = 0; i < K; i++) wt(K'(1 << i));
    endtask

    task automatic dat(input logic [8:0] pd);
        dat_pvld = 1; dat_pd = pd; step(); dat_pvld = 0; dat_pd = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input int maxc, input bit rnd);
        int n;
        n = 0;
        while (m_phase != 0 && n < maxc) begin
            if (rnd) begin
                wt_pvld = 1'($urandom_range(0, 1)); wt_sel = K'($urandom);
                dat_pvld = 1'($urandom_range(0, 1)); dat_pd = 9'($urandom);
            end
            step();
            clear_inputs();
            n++;
        end
        if (m_phase != 0) chk("idle_timeout", 32'(m_phase), 32'd0);
    endtask

    // Drive whatever is needed to get an accepted layer_end atom.
    task automatic finish_layer();
        for (int i = 0; i < 40 && m_phase == 1; i++) begin
            if (m_act) dat(9'h100 | 9'($urandom_range(0, 63)));
            else if (m_full[m_cons]) dat(9'h140);
            else wt(8'hFF);
        end
        wait_idle(20, 1'b1);
    endtask

    task automatic nominal_layer();
        int g0;
        op_start(1);
        fill8();
        g0 = go_cnt;
        dat(9'h045);
        chk("nom_rd_bank_first", 32'(mac_rd_bank), 32'd0);
        fill8();
        for (int i = 0; i < 3; i++) dat(9'(i + 1));
        dat(9'h04A);
        chk("nom_rd_bank_second", 32'(mac_rd_bank), 32'd1);
        dat(9'h00B);
        dat(9'h10C);
        chk("nom_stripe_cnt", 32'(stripe_cnt), 32'd2);
        chk("nom_go_count", 32'(go_cnt - g0), 32'd7);
        wait_idle(20, 1'b0);
        chk("nom_done_latency", 32'(done_cyc - last_go), 32'd7);
        chk("nom_err", 32'(seq2reg_err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(seq2reg_busy), 32'd0);
        chk("rst_err", 32'(seq2reg_err), 32'd0);
        chk("rst_stripe", 32'(stripe_cnt), 32'd0);
        chk("rst_wen", 32'(wt_wr_en), 32'd0);
        chk("rst_go", 32'(dat_go), 32'd0);
        chk("rst_done", 32'(seq2reg_done), 32'd0);
        rstn = 1;

        // Idle: inputs ignored
        wt(8'hFF);
        dat(9'h040);

        // Nominal layer
        nominal_layer();

        // Overflow, then op_en while busy
        op_start(0);
        fill8();
        fill8();
        wt(8'h01);
        chk("ovf_wen", 32'(last_wen), 32'd0);
        chk("ovf_err", 32'(seq2reg_err), 32'd1);
        op_start(0);
        chk("busy_op_err", 32'(seq2reg_err), 32'd9);
        dat(9'h140);
        wait_idle(20, 1'b0);

        // Underflow
        op_start(0);
        dat(9'h040);
        chk("unf_go", 32'(dat_go), 32'd0);
        chk("unf_err1", 32'(seq2reg_err[1]), 32'd1);
        chk("unf_stripe", 32'(stripe_cnt), 32'd0);
        fill8();
        dat(9'h140);
        wait_idle(20, 1'b0);

        // Stripe count mismatch
        op_start(2);
        fill8();
        dat(9'h040);
        fill8();
        dat(9'h140);
        wait_idle(20, 1'b0);
        chk("mis_err2", 32'(seq2reg_err[2]), 32'd1);
        chk("mis_done_latency", 32'(done_cyc - last_go), 32'd7);

        // Mid-layer asynchronous reset
        op_start(9);
        fill8(); dat(9'h040);
        fill8(); dat(9'h040);
        fill8(); dat(9'h040);
        chk("mid_stripe", 32'(stripe_cnt), 32'd3);
        rstn = 0;
        #1;
        chk("mid_busy", 32'(seq2reg_busy), 32'd0);
        chk("mid_stripe0", 32'(stripe_cnt), 32'd0);
        chk("mid_go", 32'(dat_go), 32'd0);
        chk("mid_wbank", 32'(wt_wr_bank), 32'd0);
        chk("mid_rd", 32'(mac_rd_bank), 32'd0);
        chk("mid_err", 32'(seq2reg_err), 32'd0);
        chk("mid_done", 32'(seq2reg_done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        idle(3);
        nominal_layer();

`ifdef NVDLA_CMAC_SEQ_PERF_EN
        op_start(1);
        fill8();
        fill8();
        dat(9'h040);
        idle(5);
        dat(9'h140);
        chk("perf_stall5", seq2reg_stall_cnt, 32'd5);
        wait_idle(20, 1'b0);
        op_start(0);
        chk("perf_clear", seq2reg_stall_cnt, 32'd0);
        finish_layer();
`endif

        // Randomized layers
        for (int l = 0; l < 12; l++) begin
            op_start($urandom_range(0, 3));
            for (int c = 0; c < 80; c++) begin
                if (m_phase != 1) break;
                op_en    = ($urandom_range(0, 99) < 3);
                wt_pvld  = 1'($urandom_range(0, 1));
                wt_sel   = $urandom_range(0, 1) ? K'($urandom) : K'(1 << $urandom_range(0, K - 1));
                dat_pvld = ($urandom_range(0, 99) < 45);
                dat_pd   = 9'($urandom);
                dat_pd[6] = ($urandom_range(0, 99) < 30);
                dat_pd[8] = ($urandom_range(0, 99) < 6);
                step();
                clear_inputs();
            end
            finish_layer();
            idle($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
